// File: rtl/counter_seek_arbiter.sv
// counter_seek_arbiter: round-robin owner of a shared wrap-around up/down
// counter. It grants one requester at a time, steps the counter along the
// shortest path to that requester's target, then pulses an acknowledge.
module counter_seek_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] tgt_i,
    input  logic [WIDTH-1:0]       cnt_val_i,
    output logic                   cnt_step_o,
    output logic                   cnt_up_o,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Half the modulus: a tie at this distance is resolved upward.
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic               cnt_up_q, cnt_up_d;
    logic               cnt_step_q, cnt_step_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;

    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [WIDTH-1:0]   diff_s;
    logic [N_REQ-1:0]   onehot_s;

    // Cyclic first-set search over req starting at the round-robin pointer.
    always_comb begin
        int pos;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        pos          = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_q) + k;
            pos = (pos >= N_REQ) ? (pos - N_REQ) : pos;
            if (!pick_found_s && req_i[IDX_W'(pos)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IDX_W'(pos);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic: latch the winner, compare, step, acknowledge.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        cnt_up_d = cnt_up_q;
        diff_s   = tgt_q - cnt_val_i;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    idx_d   = pick_idx_s;
                    tgt_d   = tgt_i[pick_idx_s*WIDTH +: WIDTH];
                    state_d = S_CMP;
                end else begin
                    cnt_up_d = 1'b0;
                end
            end
            S_CMP: begin
                if (diff_s == '0) begin
                    state_d = S_DONE;
                end else if (diff_s <= HALF) begin
                    cnt_up_d = 1'b1;
                    state_d  = S_STEP;
                end else begin
                    cnt_up_d = 1'b0;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                // Always re-check after a step so the counter never overshoots.
                state_d = S_CMP;
            end
            S_DONE: begin
                ptr_d    = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : (idx_q + IDX_W'(1));
                cnt_up_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        onehot_s   = N_REQ'(1) << idx_d;
        cnt_step_d = (state_d == S_STEP);
        busy_d     = (state_d != S_IDLE);
        gnt_d      = busy_d ? onehot_s : '0;
        ack_d      = (state_d == S_DONE) ? onehot_s : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            tgt_q      <= '0;
            cnt_up_q   <= 1'b0;
            cnt_step_q <= 1'b0;
            gnt_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            cnt_up_q   <= cnt_up_d;
            cnt_step_q <= cnt_step_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_step_o = cnt_step_q;
    assign cnt_up_o   = cnt_up_q;
    assign gnt_o      = gnt_q;
    assign ack_o      = ack_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Scoreboard bench for counter_seek_arbiter with a 1-cycle counter model.
module tb_counter_seek_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] tgt;
    logic [W-1:0]   cnt;
    logic           cnt_step, cnt_up, busy;
    logic [N-1:0]   gnt, ack;
    logic           load;
    logic [W-1:0]   load_v;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int idx;
        int ack_cyc;
        int steps;
        int ups;
        int tgtv;
    } exp_t;

    exp_t exp_q[$];

    counter_seek_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .tgt_i      (tgt),
        .cnt_val_i  (cnt),
        .cnt_step_o (cnt_step),
        .cnt_up_o   (cnt_up),
        .gnt_o      (gnt),
        .ack_o      (ack),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Cycle index: value seen after posedge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: presettable, one step per sampled cnt_step, wraps.
    always @(posedge clk) begin
        if (load) cnt <= load_v;
        else if (cnt_step) cnt <= cnt_up ? (cnt + 4'd1) : (cnt - 4'd1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Shortest-path reference: tie at half the modulus goes up.
    function automatic exp_t model(input int idx, input int start, input int tv, input int c0);
        exp_t e;
        int du;
        du = (tv - start + 16) % 16;
        e.idx  = idx;
        e.tgtv = tv;
        if (du == 0) begin
            e.steps = 0; e.ups = 0;
        end else if (du <= 8) begin
            e.steps = du; e.ups = du;
        end else begin
            e.steps = 16 - du; e.ups = 0;
        end
        e.ack_cyc = c0 + 2 + 2 * e.steps;
        return e;
    endfunction

    // Monitor: counts steps per grant and scores each ack against the queue.
    logic [N-1:0] prev_gnt_q = '0;
    int steps_q = 0;
    int ups_q = 0;
    always @(negedge clk) begin
        int st, up;
        exp_t e;
        if (rst) begin
            prev_gnt_q <= '0;
            steps_q    <= 0;
            ups_q      <= 0;
        end else begin
            st = steps_q;
            up = ups_q;
            if (prev_gnt_q == '0 && gnt != '0) begin
                st = 0; up = 0;
            end
            if (cnt_step) begin
                st++;
                if (cnt_up) up++;
                check_eq("step_while_busy", 32'(busy), 32'd1);
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("ack_idx", 32'(ack), 32'd1 << e.idx);
                    check_eq("gnt_at_ack", 32'(gnt), 32'd1 << e.idx);
                    check_eq("busy_at_ack", 32'(busy), 32'd1);
                    check_eq("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    check_eq("step_count", 32'(st), 32'(e.steps));
                    check_eq("up_steps", 32'(up), 32'(e.ups));
                    check_eq("final_count", 32'(cnt), 32'(e.tgtv));
                end
            end
            steps_q    <= st;
            ups_q      <= up;
            prev_gnt_q <= gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int v);
        load   = 1'b1;
        load_v = v[W-1:0];
        tick();
        load   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_step"}, 32'(cnt_step), 32'd0);
        check_eq({tag, "_up"},   32'(cnt_up),   32'd0);
        check_eq({tag, "_gnt"},  32'(gnt),      32'd0);
        check_eq({tag, "_ack"},  32'(ack),      32'd0);
        check_eq({tag, "_busy"}, 32'(busy),     32'd0);
    endtask

    task automatic single(input int idx, input int start, input int tv);
        set_cnt(start);
        tgt[idx*W +: W] = tv[W-1:0];
        req      = '0;
        req[idx] = 1'b1;
        exp_q.push_back(model(idx, start, tv, cyc));
        drain(60);
        req = '0;
    endtask

    initial begin
        exp_t e;
        int n, c0;
        rst = 1'b1; req = '0; tgt = '0; load = 1'b0; load_v = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) tick();
        check_idle_outputs("idle_noreq");

        // Zero-distance, wrap-up, plain down, tie-goes-up.
        single(0, 5, 5);
        single(1, 14, 1);
        single(2, 5, 2);
        single(3, 0, 8);

        // All four requesting; round-robin order then re-grant of 0.
        set_cnt(0);
        tgt = {4'd15, 4'd0, 4'd3, 4'd3};
        req = 4'b1111;
        e = model(0, 0, 3, cyc);        exp_q.push_back(e);
        e = model(1, 3, 3, e.ack_cyc + 1);  exp_q.push_back(e);
        e = model(2, 3, 0, e.ack_cyc + 1);  exp_q.push_back(e);
        e = model(3, 0, 15, e.ack_cyc + 1); exp_q.push_back(e);
        e = model(0, 15, 3, e.ack_cyc + 1); exp_q.push_back(e);
        drain(200);
        req = '0;

        // Move pointer to 2, then abort a 6-step move with reset.
        single(1, 0, 0);
        set_cnt(0);
        tgt[2*W +: W] = 4'd6;
        req = 4'b0100;
        n = 0;
        c0 = 0;
        while (c0 < 3 && n < 40) begin
            tick();
            n++;
            if (cnt_step) c0++;
        end
        check_eq("abort_step_reached", 32'(c0), 32'd3);
        rst = 1'b1;
        tick();
        check_idle_outputs("abort");
        check_eq("abort_cnt_kept", 32'(cnt), 32'd3);
        rst = 1'b0;
        req = '0;
        repeat (4) tick();
        check_idle_outputs("post_abort");

        // Pointer must restart at 0: requester 1 wins over 3.
        tgt[1*W +: W] = 4'd5;
        tgt[3*W +: W] = 4'd3;
        req = 4'b1010;
        e = model(1, 3, 5, cyc);           exp_q.push_back(e);
        e = model(3, 5, 3, e.ack_cyc + 1); exp_q.push_back(e);
        drain(80);
        req = '0;

        // Drop req and change tgt mid-transaction: latched target wins.
        set_cnt(14);
        tgt[2*W +: W] = 4'd10;
        req = 4'b0100;
        exp_q.push_back(model(2, 14, 10, cyc));
        repeat (3) tick();
        req = '0;
        tgt[2*W +: W] = 4'd0;
        drain(60);
        repeat (6) tick();
        check_idle_outputs("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
